// File: rtl/recon_join_unit.sv
// Reconstruction join: per TU, merges intra/inter prediction with residuals,
// clips pred+resi to the latched bit depth and queues recon beats in a small FIFO.
module recon_join_unit #(
   parameter int bitDepthY = 10,
   parameter int nSamples  = 16,
   parameter int OUT_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               arst_n,
   input  logic                               cmd_val,
   output logic                               cmd_rdy,
   input  logic                               cmd_isInter,
   input  logic                               cmd_cbf,
   input  logic [2:0]                         cmd_tuSizeLog2,
   input  logic [3:0]                         gp_bitDepth,
   input  logic [bitDepthY*nSamples-1:0]      predSamples_intra,
   input  logic                               intra_pred_val,
   output logic                               intra_pred_rdy,
   input  logic [bitDepthY*nSamples-1:0]      predSamples_inter,
   input  logic                               inter_pred_val,
   output logic                               inter_pred_rdy,
   input  logic [(bitDepthY+1)*nSamples-1:0]  residuals,
   input  logic                               resi_val,
   output logic                               resi_rdy,
   output logic [bitDepthY*nSamples-1:0]      r_reconSamples,
   output logic                               recon_val,
   input  logic                               recon_rdy,
   output logic                               tu_done,
   output logic                               busy
);

   localparam int BW = bitDepthY * nSamples;
   localparam int RW = bitDepthY + 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic            is_inter_q, is_inter_d;
   logic            cbf_q, cbf_d;
   logic [5:0]      last_q, last_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [3:0]      bd_q, bd_d;
   logic            tu_done_q, tu_done_d;

   logic [BW-1:0]   mem_q [OUT_DEPTH];
   logic [PW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q;

   logic            not_full, pred_v, resi_ok, fire, pop;
   logic [BW-1:0]   pred_sel, recon_beat;
   logic [bitDepthY-1:0]        p_s;
   logic [RW-1:0]               r_s;
   logic signed [bitDepthY+1:0] sum_s;
   logic [bitDepthY+1:0]        max_u;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Registered count gates the push, so a full FIFO never pushes and pops together.
   assign not_full  = count_q < CW'(OUT_DEPTH);
   assign recon_val = count_q != '0;
   assign pop       = recon_val & recon_rdy;
   assign busy      = (state_q == RUN) | recon_val;
   assign tu_done   = tu_done_q;
   assign r_reconSamples = recon_val ? mem_q[rd_q] : '0;

   always_comb begin
      state_d        = state_q;
      is_inter_d     = is_inter_q;
      cbf_d          = cbf_q;
      last_d         = last_q;
      cnt_d          = cnt_q;
      bd_d           = bd_q;
      tu_done_d      = 1'b0;
      cmd_rdy        = 1'b0;
      intra_pred_rdy = 1'b0;
      inter_pred_rdy = 1'b0;
      resi_rdy       = 1'b0;
      fire           = 1'b0;
      pred_v         = is_inter_q ? inter_pred_val : intra_pred_val;
      resi_ok        = cbf_q ? resi_val : 1'b1;
      unique case (state_q)
         IDLE: begin
            cmd_rdy = 1'b1;
            if (cmd_val) begin
               is_inter_d = cmd_isInter;
               cbf_d      = cmd_cbf;
               unique case (cmd_tuSizeLog2)
                  3'd3:    last_d = 6'd3;
                  3'd4:    last_d = 6'd15;
                  3'd5:    last_d = 6'd63;
                  default: last_d = 6'd0;
               endcase
               bd_d    = (gp_bitDepth > 4'(bitDepthY)) ? 4'(bitDepthY) : gp_bitDepth;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            intra_pred_rdy = ~is_inter_q & not_full & resi_ok;
            inter_pred_rdy =  is_inter_q & not_full & resi_ok;
            resi_rdy       = cbf_q & not_full & pred_v;
            fire           = pred_v & resi_ok & not_full;
            if (fire) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == last_q) begin
                  state_d   = IDLE;
                  tu_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pred_sel   = is_inter_q ? predSamples_inter : predSamples_intra;
      max_u      = ((bitDepthY+2)'(1) << bd_q) - (bitDepthY+2)'(1);
      recon_beat = '0;
      p_s        = '0;
      r_s        = '0;
      sum_s      = '0;
      for (int unsigned i = 0; i < nSamples; i++) begin
         p_s   = pred_sel[i*bitDepthY +: bitDepthY];
         r_s   = cbf_q ? residuals[i*RW +: RW] : '0;
         sum_s = $signed({2'b00, p_s}) + $signed({r_s[RW-1], r_s});
         if (sum_s < 0)
            recon_beat[i*bitDepthY +: bitDepthY] = '0;
         else if (sum_s > $signed(max_u))
            recon_beat[i*bitDepthY +: bitDepthY] = max_u[bitDepthY-1:0];
         else
            recon_beat[i*bitDepthY +: bitDepthY] = sum_s[bitDepthY-1:0];
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         is_inter_q <= 1'b0;
         cbf_q      <= 1'b0;
         last_q     <= '0;
         cnt_q      <= '0;
         bd_q       <= '0;
         tu_done_q  <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         is_inter_q <= is_inter_d;
         cbf_q      <= cbf_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         bd_q       <= bd_d;
         tu_done_q  <= tu_done_d;
         if (fire) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         unique case ({fire, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fire) mem_q[wr_q] <= recon_beat;
   end

endmodule

// File: tb/tb_recon_join_unit.sv
// Scoreboard bench for recon_join_unit: expected beats queued at each modelled fire,
// compared in order as recon beats leave the FIFO.
module tb_recon_join_unit;

   localparam int BD  = 10;
   localparam int NS  = 16;
   localparam int DEP = 2;
   localparam int BW  = BD * NS;
   localparam int RW  = BD + 1;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic cmd_val = 1'b0, cmd_rdy, cmd_isInter = 1'b0, cmd_cbf = 1'b0;
   logic [2:0] cmd_tuSizeLog2 = '0;
   logic [3:0] gp_bitDepth = '0;
   logic [BW-1:0] predSamples_intra = '0, predSamples_inter = '0;
   logic intra_pred_val = 1'b0, intra_pred_rdy, inter_pred_val = 1'b0, inter_pred_rdy;
   logic [RW*NS-1:0] residuals = '0;
   logic resi_val = 1'b0, resi_rdy;
   logic [BW-1:0] r_reconSamples;
   logic recon_val, recon_rdy = 1'b1, tu_done, busy;

   always #5 clk = ~clk;

   recon_join_unit #(.bitDepthY(BD), .nSamples(NS), .OUT_DEPTH(DEP)) dut (
      .clk(clk), .arst_n(arst_n),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_isInter(cmd_isInter), .cmd_cbf(cmd_cbf),
      .cmd_tuSizeLog2(cmd_tuSizeLog2), .gp_bitDepth(gp_bitDepth),
      .predSamples_intra(predSamples_intra), .intra_pred_val(intra_pred_val),
      .intra_pred_rdy(intra_pred_rdy),
      .predSamples_inter(predSamples_inter), .inter_pred_val(inter_pred_val),
      .inter_pred_rdy(inter_pred_rdy),
      .residuals(residuals), .resi_val(resi_val), .resi_rdy(resi_rdy),
      .r_reconSamples(r_reconSamples), .recon_val(recon_val), .recon_rdy(recon_rdy),
      .tu_done(tu_done), .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int clip(input int s, input int bd);
      int mx;
      mx = (1 << bd) - 1;
      if (s < 0) return 0;
      if (s > mx) return mx;
      return s;
   endfunction

   function automatic logic [BW-1:0] exp_beat(input logic [BW-1:0] pb,
                                              input logic [RW*NS-1:0] rb, input int bd);
      logic [BW-1:0] res;
      logic signed [RW-1:0] rs;
      int p;
      res = '0;
      for (int i = 0; i < NS; i++) begin
         p  = int'(pb[i*BD +: BD]);
         rs = rb[i*RW +: RW];
         res[i*BD +: BD] = BD'(clip(p + int'(rs), bd));
      end
      return res;
   endfunction

   // Reference model state
   logic [BW-1:0] q[$];
   bit m_run = 0, m_inter = 0, m_cbf = 0, m_done = 0;
   int m_total = 0, m_fired = 0, m_bd = 0;
   int pops = 0, cyc = 0, accepts = 0, last_fire_cyc = 0;
   bit gap_check = 0, gap_armed = 0;
   bit notfull, resi_ok, predv, pfire, sel_ok;

   always @(negedge clk) begin
      cyc++;
      if (!arst_n) begin
         chk("rst_ctrl", {recon_val, tu_done, busy, intra_pred_rdy, inter_pred_rdy, resi_rdy, cmd_rdy},
             7'b0000001);
         chk("rst_data", r_reconSamples, '0);
         q.delete();
         m_run  = 0;
         m_done = 0;
      end else begin
         notfull = q.size() < DEP;
         predv   = m_inter ? inter_pred_val : intra_pred_val;
         resi_ok = m_cbf ? resi_val : 1'b1;
         sel_ok  = m_run && notfull && resi_ok;
         chk("recon_val", recon_val, q.size() != 0);
         chk("busy", busy, m_run || q.size() != 0);
         chk("cmd_rdy", cmd_rdy, !m_run);
         chk("tu_done", tu_done, m_done);
         chk("intra_rdy", intra_pred_rdy, sel_ok && !m_inter);
         chk("inter_rdy", inter_pred_rdy, sel_ok && m_inter);
         chk("resi_rdy", resi_rdy, m_run && m_cbf && notfull && predv);
         if (q.size() != 0 && recon_rdy) begin
            chk("beat", r_reconSamples, q.pop_front());
            pops++;
         end
         pfire  = sel_ok && predv;
         m_done = 0;
         if (pfire) begin
            q.push_back(exp_beat(m_inter ? predSamples_inter : predSamples_intra,
                                 m_cbf ? residuals : '0, m_bd));
            m_fired++;
            if (m_fired == m_total) begin
               m_run  = 0;
               m_done = 1;
               last_fire_cyc = cyc;
            end
         end else if (!m_run && cmd_val) begin
            m_run   = 1;
            m_inter = cmd_isInter;
            m_cbf   = cmd_cbf;
            m_fired = 0;
            m_bd    = (gp_bitDepth > BD) ? BD : int'(gp_bitDepth);
            case (cmd_tuSizeLog2)
               3'd3:    m_total = 4;
               3'd4:    m_total = 16;
               3'd5:    m_total = 64;
               default: m_total = 1;
            endcase
            if (gap_check) begin
               if (gap_armed) chk("cmd_gap", cyc - last_fire_cyc, 1);
               gap_armed = 1;
            end
            accepts++;
         end
      end
   end

   bit rdy_rand = 0;
   initial forever begin
      @(posedge clk);
      #1;
      recon_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input bit inter, input bit cbf, input logic [2:0] lg, input logic [3:0] gbd);
      bit ok;
      ok = 0;
      cmd_isInter = inter; cmd_cbf = cbf; cmd_tuSizeLog2 = lg; gp_bitDepth = gbd;
      cmd_val = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (cmd_rdy) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      cmd_val = 1'b0;
      cmd_isInter = 1'($urandom); cmd_cbf = 1'($urandom);
      cmd_tuSizeLog2 = 3'($urandom); gp_bitDepth = 4'($urandom);
      chk("cmd_timeout", ok, 1);
   endtask

   task automatic send_beat(input bit inter, input bit rnd, input int pv, input int rv);
      bit ok;
      ok = 0;
      for (int i = 0; i < NS; i++) begin
         if (inter) begin
            predSamples_inter[i*BD +: BD] = rnd ? BD'($urandom_range(0, 1023)) : BD'(pv);
            predSamples_intra[i*BD +: BD] = BD'($urandom);
         end else begin
            predSamples_intra[i*BD +: BD] = rnd ? BD'($urandom_range(0, 1023)) : BD'(pv);
            predSamples_inter[i*BD +: BD] = BD'($urandom);
         end
         residuals[i*RW +: RW] = rnd ? RW'(int'($urandom_range(0, 2047)) - 1024) : RW'(rv);
      end
      intra_pred_val = 1'b1;
      inter_pred_val = 1'b1;
      resi_val = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (inter ? inter_pred_rdy : intra_pred_rdy) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      chk("beat_timeout", ok, 1);
   endtask

   task automatic idle_inputs();
      intra_pred_val = 1'b0;
      inter_pred_val = 1'b0;
      resi_val = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (q.size() == 0 && !m_run) break;
      end
      @(posedge clk); #1;
      chk("drain", q.size(), 0);
   endtask

   int p0, a0;

   initial begin
      repeat (3) @(posedge clk);
      #1 arst_n = 1'b1;
      @(posedge clk); #1;

      // Clip to zero, bd=10, single beat
      send_cmd(0, 1, 3'd2, 4'd10);
      send_beat(0, 0, 512, -600);
      idle_inputs();
      drain();

      // Upper clip at bd=8, then bd clamped to 10 with out-of-range log2 (1 beat)
      send_cmd(0, 1, 3'd2, 4'd8);
      send_beat(0, 0, 1000, 100);
      idle_inputs();
      drain();
      send_cmd(0, 1, 3'd0, 4'd12);
      send_beat(0, 0, 1000, 100);
      idle_inputs();
      drain();

      // Inter, cbf=0 bypass, 4 beats
      send_cmd(1, 0, 3'd3, 4'd10);
      for (int b = 1; b <= 4; b++) send_beat(1, 0, b, 77);
      idle_inputs();
      drain();

      // 64 random beats under random backpressure
      rdy_rand = 1;
      p0 = pops;
      send_cmd(0, 1, 3'd5, 4'd9);
      for (int b = 0; b < 64; b++) send_beat(0, 1, 0, 0);
      idle_inputs();
      drain();
      rdy_rand = 0;
      chk("beats64", pops - p0, 64);

      // Reset mid-TU, then a fresh TU
      send_cmd(1, 1, 3'd4, 4'd10);
      for (int b = 0; b < 7; b++) send_beat(1, 1, 0, 0);
      arst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      @(posedge clk); #1;
      send_cmd(0, 1, 3'd2, 4'd10);
      send_beat(0, 0, 300, 45);
      idle_inputs();
      drain();

      // cmd_val held high across two back-to-back TUs
      gap_check = 1;
      gap_armed = 0;
      a0 = accepts;
      cmd_isInter = 1'b0; cmd_cbf = 1'b1; cmd_tuSizeLog2 = 3'd2; gp_bitDepth = 4'd10;
      cmd_val = 1'b1;
      send_beat(0, 0, 700, -5);
      send_beat(0, 0, 20, -21);
      cmd_val = 1'b0;
      idle_inputs();
      drain();
      gap_check = 0;
      chk("accepts", accepts - a0, 2);

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
